// File: rtl/pixel_packer.sv
// Packs one RGB pixel per clk_9 into a 16-bit word and buffers it in a DEPTH-entry FIFO with overflow and word accounting.
// Optional macro PIXEL_PACKER_RGB565_EN selects RGB565 packing instead of the default {blue, red} format.
module pixel_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 20
) (
  input  logic             clk_9,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       red_pix,
  input  logic [7:0]       green_pix,
  input  logic [7:0]       blue_pix,
  input  logic             frame_start,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             full,
  output logic             overflow,
  output logic [7:0]       drop_count,
  output logic [CNT_W-1:0] word_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [15:0]      r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic [7:0]       r_drop_count;
  logic [CNT_W-1:0] r_word_count;

  logic [15:0]      w_word;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_valid;

`ifdef PIXEL_PACKER_RGB565_EN
  assign w_word = {red_pix[7:3], green_pix[7:2], blue_pix[7:3]};
`else
  assign w_word = {blue_pix, red_pix};
`endif

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == DEPTH_C);
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_pop   = w_valid & out_ready;
  assign w_push  = en & (~w_full | w_pop);
  assign w_drop  = en & ~w_push;

  always_ff @(posedge clk_9) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_word_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
      if (frame_start) begin
        r_word_count <= w_push ? CNT_W'(1) : '0;
      end else if (w_push) begin
        r_word_count <= r_word_count + CNT_W'(1);
      end
    end
  end

  assign out_data   = r_mem[r_rd_ptr];
  assign out_valid  = w_valid;
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign word_count = r_word_count;

endmodule
